// File: rtl/matrix_stream_dp.sv
// rtl/matrix_stream_dp.sv - matrix store RAM with strided read sequencer and prefetch stream
//
// Purpose:
//   Single-port inferred RAM holding a matrix, plus a read sequencer that walks
//   base + k*stride (k = 0..len-1, address wraps modulo depth) and delivers the
//   words on a valid/ready stream. A credit-limited prefetch FIFO hides the RAM
//   read latency so the stream can run at one word per clock.
//
// Ports:
//   clka      clock, all logic on posedge
//   rsta_n    synchronous active-low reset (RAM contents are kept)
//   wea       host write enable, mem[addra] <= dina; owns the RAM that cycle
//   addra     host write address
//   dina      host write data
//   start     launch a read sequence (sampled only while idle)
//   base      first read address
//   stride    address increment per element
//   len       element count, 0..depth
//   abort     cancel the active sequence
//   rd_data   stream data (FIFO head)
//   rd_valid  stream data valid
//   rd_ready  consumer accepts when rd_valid & rd_ready
//   busy      sequence active
//   done      one-clock pulse when the last element is accepted (or after a len=0 start)
module matrix_stream_dp #(
   parameter int ADDR_MSB  = 11,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 2,
   parameter int BUF_DEPTH = 4
) (
   input  logic                clka,
   input  logic                rsta_n,
   input  logic                wea,
   input  logic [ADDR_MSB:0]   addra,
   input  logic [DATA_W-1:0]   dina,
   input  logic                start,
   input  logic [ADDR_MSB:0]   base,
   input  logic [ADDR_MSB:0]   stride,
   input  logic [ADDR_MSB+1:0] len,
   input  logic                abort,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic                busy,
   output logic                done
);

   localparam int DEPTH = 2**(ADDR_MSB+1);
   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH+1);
   localparam int OCC_W = $clog2(BUF_DEPTH+RD_LAT+1) + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH-1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [1:0]          r_state;
   logic [ADDR_MSB:0]   r_addr;
   logic [ADDR_MSB:0]   r_stride;
   logic [ADDR_MSB+1:0] r_len;
   logic [ADDR_MSB+1:0] r_issue_cnt;
   logic                r_zl_done;
   logic [DATA_W-1:0]   r_pipe_data [RD_LAT];
   logic [RD_LAT-1:0]   r_pipe_vld;
   logic [DATA_W-1:0]   r_fifo [BUF_DEPTH];
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_W-1:0]    r_fifo_cnt;

   logic                w_abort;
   logic                w_issue;
   logic                w_last_issue;
   logic                w_push;
   logic                w_pop;
   logic                w_last_acc;
   logic [OCC_W-1:0]    w_inflight;
   logic [OCC_W-1:0]    w_occ;

   // Reads still travelling through the RAM output pipeline.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + OCC_W'(r_pipe_vld[i]);
      end
   end

   // Credit: every issued read already owns a FIFO slot, so a push can never
   // overflow. Occupancy is taken before this cycle's pop.
   assign w_occ        = OCC_W'(r_fifo_cnt) + w_inflight;
   assign w_abort      = abort && (r_state != S_IDLE);
   assign w_issue      = (r_state == S_RUN) && (r_issue_cnt < r_len) && !wea && !w_abort
                         && (w_occ < OCC_W'(BUF_DEPTH));
   assign w_last_issue = w_issue && (r_issue_cnt == r_len - 1'b1);
   assign w_push       = r_pipe_vld[RD_LAT-1];

   assign rd_valid     = (r_fifo_cnt != '0);
   assign rd_data      = rd_valid ? r_fifo[r_rd_ptr] : '0;
   assign w_pop        = rd_valid && rd_ready;

   // In DRAIN nothing new is issued, so the last element is the only word left
   // anywhere in the pipe/FIFO.
   assign w_last_acc   = (r_state == S_DRAIN) && !abort && w_pop
                         && (r_fifo_cnt == CNT_W'(1)) && (w_inflight == '0);

   assign busy         = (r_state != S_IDLE);
   assign done         = r_zl_done || w_last_acc;

   // RAM and its output data pipeline; a write blocks the read issue that cycle.
   always_ff @(posedge clka) begin
      if (wea) begin
         r_mem[addra] <= dina;
      end
      if (w_issue) begin
         r_pipe_data[0] <= r_mem[r_addr];
      end
      for (int i = 1; i < RD_LAT; i++) begin
         r_pipe_data[i] <= r_pipe_data[i-1];
      end
   end

   always_ff @(posedge clka) begin
      if (!rsta_n || w_abort) begin
         r_pipe_vld <= '0;
      end else begin
         r_pipe_vld[0] <= w_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
         end
      end
   end

   always_ff @(posedge clka) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= r_pipe_data[RD_LAT-1];
      end
   end

   always_ff @(posedge clka) begin
      if (!rsta_n || w_abort) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clka) begin
      if (!rsta_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_stride    <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_zl_done   <= 1'b0;
      end else begin
         r_zl_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     r_state     <= S_RUN;
                     r_addr      <= base;
                     r_stride    <= stride;
                     r_len       <= len;
                     r_issue_cnt <= '0;
                  end else begin
                     r_zl_done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
               end else if (w_issue) begin
                  // Address arithmetic wraps naturally modulo depth.
                  r_addr      <= r_addr + r_stride;
                  r_issue_cnt <= r_issue_cnt + 1'b1;
                  if (w_last_issue) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_abort || w_last_acc) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
